edge_loader: RTL and testbench
==============================

# edge_loader

Stream-fed edge buffer upstream of the CGRA router FSM. It accepts the DFG edge list over a valid/ready stream, filters and stores it in a local edge memory, and reports the count. It then pulses `start` to the router and serves the router's edge reads until the router signals completion. This replaces file-based initialisation of the router's edge memory with a synthesizable load path.

## Interface
Parameters:
- `MAX_EDGES`, 11: edge memory depth.
- `GRID_DIM`, 4: CGRA side length. PE index = y*GRID_DIM + x.
- `EDGE_W`, 8: edge word width. [7:4] = src PE, [3:0] = dst PE.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: upstream edge word valid.
- `in_ready`  out  1: loader accepts a word this cycle.
- `in_data`  in  EDGE_W: edge word.
- `in_last`  in  1: marks the final word of a batch. Qualified by the handshake.
- `start`  out  1: one-cycle pulse; the edge list is ready for the router.
- `router_done`  in  1: router finished the current batch.
- `rd_addr`  in  $clog2(MAX_EDGES): router edge read address.
- `rd_data`  out  EDGE_W: edge at `rd_addr`, combinational read.
- `edge_count`  out  $clog2(MAX_EDGES+1): number of edges stored.
- `err_selfloop`  out  1: sticky; the batch contained src==dst edges.
- `err_overflow`  out  1: sticky; the batch had more than MAX_EDGES valid edges.

## Operation
- States: S_LOAD, S_START, S_WAIT.
- **S_LOAD**
  - `in_ready`=1.
  - On an accepted beat, the word is classified:
    - src==dst: dropped, `err_selfloop`<=1.
    - `edge_count`==MAX_EDGES: dropped, `err_overflow`<=1.
    - Otherwise: written to mem[`edge_count`], and `edge_count` increments.
  - An accepted beat with `in_last`=1 moves to S_START, whatever its classification.
- **S_START**
  - `start`=1 for exactly this cycle, `in_ready`=0.
  - Always moves to S_WAIT, including for a zero-edge batch.
- **S_WAIT**
  - `in_ready`=0, and memory is frozen.
  - `router_done`=1 moves to S_LOAD.
  - `router_done` is ignored in every other state.
- **Batch clear:** the first accepted beat in S_LOAD after S_WAIT clears `edge_count`, `err_selfloop` and `err_overflow` before that beat is classified. The beat's own effects apply on top of the clear, so results stay readable between batches.
- **Read port:**
  - `rd_data` = mem[`rd_addr`] when `rd_addr` < `edge_count`.
  - Otherwise `rd_data` = 0, including out-of-range addresses. Stale contents are never visible.
- **Reset**, including mid-batch and mid-S_WAIT:
  - state=S_LOAD, `edge_count`=0, both error flags=0, `start`=0, batch-clear pending=0.
  - Memory contents are not cleared; the read rule above masks them.
- **Widths:** `edge_count` saturates at MAX_EDGES and never wraps.

## Timing
- `in_ready` is a combinational decode of state only. It does not depend on `in_valid`.
- A beat is accepted on a clk edge where `in_valid`&&`in_ready`.
- Write, count and flag updates are visible the cycle after acceptance.
- Last beat accepted at edge N: `start`=1 during cycle N+1 (S_START), S_WAIT from N+2.
- `router_done` sampled high at edge M in S_WAIT: `in_ready`=1 from cycle M+1.
- `router_done` held high across cycles is harmless.
- Read latency is 0 cycles, combinational from `rd_addr`.
- Reset values: `in_ready`=1, `start`=0, `edge_count`=0, `err_*`=0, `rd_data`=0.

## Structure
- Shared package `cgra_routing_pkg`:
  - `GRID_DIM`, `NUM_PE`.
  - `edge_t` packed struct {src[3:0], dst[3:0]}.
  - The loader state enum.
  - The router's state constants, migrated from parameters.
- One sub-module: `edge_mem`, a MAX_EDGES x EDGE_W register array with single write port and combinational read. Loader FSM, count and flags stay in `edge_loader`.

## Test plan
- Reset, then 3 beats 0x12, 0x34, 0x56 (last on third) -> `start` pulse one cycle after the third beat; `edge_count`=3; rd 0..2 = 0x12/0x34/0x56; rd 3 = 0x00.
- Beats 0x11, 0x23 (last) -> `edge_count`=1, `err_selfloop`=1, mem[0]=0x23, `start` pulses.
- 13 distinct valid edges -> `edge_count`=11, `err_overflow`=1, rd 10 = 11th edge, `start` after 13th beat.
- `in_valid` toggling with random gaps, plus `in_valid` during S_START/S_WAIT -> no beat accepted while `in_ready`=0; `router_done` pulse returns `in_ready`=1 next cycle.
- Second batch (0x9A last) after first with errors -> flags and count still set until its accepted beat; then `edge_count`=1, flags 0, rd 1 = 0x00.
- Reset asserted in S_WAIT with `edge_count`=5 -> next cycle `in_ready`=1, `edge_count`=0, rd 0 = 0x00, no `start`.

Source files
------------

// File: rtl/cgra_routing_pkg.sv
// Shared types and constants for the CGRA routing path: grid geometry, the edge
// word layout, the edge loader state encoding and the router state constants.
package cgra_routing_pkg;

  localparam int unsigned GRID_DIM = 4;
  localparam int unsigned NUM_PE   = GRID_DIM * GRID_DIM;
  localparam int unsigned PE_W     = $clog2(NUM_PE);
  localparam int unsigned EDGE_W   = 2 * PE_W;

  // One DFG edge: source PE in the upper field, destination PE in the lower.
  typedef struct packed {
    logic [PE_W-1:0] src;
    logic [PE_W-1:0] dst;
  } edge_t;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } loader_state_t;

  // Router FSM state encoding.
  localparam logic [2:0] ROUTER_IDLE   = 3'd0;
  localparam logic [2:0] ROUTER_FETCH  = 3'd1;
  localparam logic [2:0] ROUTER_ROUTE  = 3'd2;
  localparam logic [2:0] ROUTER_COMMIT = 3'd3;
  localparam logic [2:0] ROUTER_DONE   = 3'd4;

  // Linear PE index from grid coordinates.
  function automatic logic [PE_W-1:0] pe_index(input int unsigned x, input int unsigned y);
    return PE_W'(y * GRID_DIM + x);
  endfunction

endpackage

// File: rtl/edge_mem.sv
// Edge storage: DEPTH x WIDTH register array, one synchronous write port and one
// combinational read port. Reads beyond DEPTH return zero.
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address (caller keeps it below DEPTH)
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - combinational read data
module edge_mem #(
  parameter int unsigned DEPTH = 11,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset; the loader masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < (AW + 1)'(DEPTH)) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/edge_loader.sv
// Stream-fed edge buffer in front of the CGRA router. Accepts a batch of edge
// words over valid/ready, drops self-loops and excess edges (flagging each),
// pulses start, then serves router reads until router_done.
//   clk, reset     - clock, synchronous active-high reset
//   in_valid/ready - upstream handshake; in_ready decodes state only
//   in_data        - edge word {src, dst}
//   in_last        - final word of the batch
//   start          - one-cycle pulse, edge list ready
//   router_done    - router finished; honoured only while waiting
//   rd_addr        - router read address
//   rd_data        - combinational read, zero at or above edge_count
//   edge_count     - edges stored in the current batch
//   err_selfloop   - sticky, a src==dst edge was dropped
//   err_overflow   - sticky, an edge was dropped because memory was full
module edge_loader
  import cgra_routing_pkg::*;
#(
  parameter int unsigned MAX_EDGES = 11,
  parameter int unsigned GRID_DIM  = 4,
  parameter int unsigned EDGE_W    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EDGE_W-1:0]              in_data,
  input  logic                           in_last,
  output logic                           start,
  input  logic                           router_done,
  input  logic [$clog2(MAX_EDGES)-1:0]   rd_addr,
  output logic [EDGE_W-1:0]              rd_data,
  output logic [$clog2(MAX_EDGES+1)-1:0] edge_count,
  output logic                           err_selfloop,
  output logic                           err_overflow
);

  localparam int unsigned AW         = $clog2(MAX_EDGES);
  localparam int unsigned CW         = $clog2(MAX_EDGES + 1);
  localparam int unsigned PE_FIELD_W = $clog2(GRID_DIM * GRID_DIM);

  loader_state_t   state, state_next;
  logic [CW-1:0]   count_next;
  logic            selfloop_next;
  logic            overflow_next;
  logic            clear_pending, clear_next;
  logic            beat_selfloop;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [EDGE_W-1:0] mem_rd_data;

  assign beat_selfloop = in_data[2*PE_FIELD_W-1:PE_FIELD_W] == in_data[PE_FIELD_W-1:0];

  // State, count, flags and the deferred batch-clear marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_LOAD;
      edge_count    <= '0;
      err_selfloop  <= 1'b0;
      err_overflow  <= 1'b0;
      clear_pending <= 1'b0;
    end else begin
      state         <= state_next;
      edge_count    <= count_next;
      err_selfloop  <= selfloop_next;
      err_overflow  <= overflow_next;
      clear_pending <= clear_next;
    end
  end

  // Next-state, beat classification and handshake/start decode.
  always_comb begin
    state_next    = state;
    count_next    = edge_count;
    selfloop_next = err_selfloop;
    overflow_next = err_overflow;
    clear_next    = clear_pending;
    in_ready      = 1'b0;
    start         = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;

    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Previous batch stays readable until the first beat of the next one.
          if (clear_pending) begin
            count_next    = '0;
            selfloop_next = 1'b0;
            overflow_next = 1'b0;
            clear_next    = 1'b0;
          end
          if (beat_selfloop) begin
            selfloop_next = 1'b1;
          end else if (count_next == CW'(MAX_EDGES)) begin
            overflow_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_addr    = AW'(count_next);
            count_next = count_next + CW'(1);
          end
          if (in_last) begin
            state_next = S_START;
          end
        end
      end
      S_START: begin
        start      = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (router_done) begin
          state_next = S_LOAD;
          clear_next = 1'b1;
        end
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase
  end

  edge_mem #(
    .DEPTH (MAX_EDGES),
    .WIDTH (EDGE_W)
  ) u_edge_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (mem_rd_data)
  );

  // Only entries of the current batch are visible.
  assign rd_data = (CW'(rd_addr) < edge_count) ? mem_rd_data : '0;

endmodule

// File: tb/tb_edge_loader.sv
// Directed self-checking bench for edge_loader.
module tb_edge_loader;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       start;
  logic       router_done;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] edge_count;
  logic       err_selfloop;
  logic       err_overflow;

  int checks;
  int failures;

  edge_loader #(
    .MAX_EDGES (11),
    .GRID_DIM  (4),
    .EDGE_W    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .start        (start),
    .router_done  (router_done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .edge_count   (edge_count),
    .err_selfloop (err_selfloop),
    .err_overflow (err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic set_rd(input logic [3:0] a);
    rd_addr = a;
    #1;
  endtask

  task automatic pulse_done();
    router_done = 1'b1;
    tick();
    router_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    set_rd(4'd0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b exp=0", start); end
    checks++; if (edge_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", edge_count); end
    checks++; if ({err_selfloop, err_overflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {err_selfloop, err_overflow}); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd0 got=%h exp=00", rd_data); end
  endtask

  task automatic test_basic();
    send_beat(8'h12, 1'b0);
    checks++; if (edge_count !== 4'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", edge_count); end
    send_beat(8'h34, 1'b0);
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL basic_early_start got=%0b exp=0", start); end
    send_beat(8'h56, 1'b1);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL basic_start got=%0b exp=1", start); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_start got=%0b exp=0", in_ready); end
    checks++; if (edge_count !== 4'd3) begin failures++; $display("FAIL basic_count3 got=%0d exp=3", edge_count); end
    tick();
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL basic_start_width got=%0b exp=0", start); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_wait got=%0b exp=0", in_ready); end
    set_rd(4'd0);
    checks++; if (rd_data !== 8'h12) begin failures++; $display("FAIL basic_rd0 got=%h exp=12", rd_data); end
    set_rd(4'd1);
    checks++; if (rd_data !== 8'h34) begin failures++; $display("FAIL basic_rd1 got=%h exp=34", rd_data); end
    set_rd(4'd2);
    checks++; if (rd_data !== 8'h56) begin failures++; $display("FAIL basic_rd2 got=%h exp=56", rd_data); end
    set_rd(4'd3);
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL basic_rd3 got=%h exp=00", rd_data); end
    pulse_done();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_done_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_selfloop();
    send_beat(8'h11, 1'b0);
    checks++; if (edge_count !== 4'd0) begin failures++; $display("FAIL self_clear_count got=%0d exp=0", edge_count); end
    checks++; if (err_selfloop !== 1'b1) begin failures++; $display("FAIL self_flag_early got=%0b exp=1", err_selfloop); end
    send_beat(8'h23, 1'b1);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL self_start got=%0b exp=1", start); end
    checks++; if (edge_count !== 4'd1) begin failures++; $display("FAIL self_count got=%0d exp=1", edge_count); end
    checks++; if ({err_selfloop, err_overflow} !== 2'b10) begin failures++; $display("FAIL self_flags got=%b exp=10", {err_selfloop, err_overflow}); end
    set_rd(4'd0);
    checks++; if (rd_data !== 8'h23) begin failures++; $display("FAIL self_rd0 got=%h exp=23", rd_data); end
    set_rd(4'd1);
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL self_rd1 got=%h exp=00", rd_data); end
    tick();
    pulse_done();
  endtask

  task automatic test_overflow();
    logic [3:0] a;
    logic [3:0] b;
    for (int i = 0; i < 13; i++) begin
      a = 4'(i);
      b = 4'(i + 1);
      send_beat({a, b}, (i == 12));
      if (i == 10) begin
        checks++; if (edge_count !== 4'd11) begin failures++; $display("FAIL ovf_count_full got=%0d exp=11", edge_count); end
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_flag_early got=%0b exp=0", err_overflow); end
      end
      if (i == 11) begin
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag_set got=%0b exp=1", err_overflow); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL ovf_start_early got=%0b exp=0", start); end
      end
    end
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL ovf_start got=%0b exp=1", start); end
    checks++; if (edge_count !== 4'd11) begin failures++; $display("FAIL ovf_count_sat got=%0d exp=11", edge_count); end
    checks++; if ({err_selfloop, err_overflow} !== 2'b01) begin failures++; $display("FAIL ovf_flags got=%b exp=01", {err_selfloop, err_overflow}); end
    tick();
    set_rd(4'd10);
    checks++; if (rd_data !== 8'hAB) begin failures++; $display("FAIL ovf_rd10 got=%h exp=ab", rd_data); end
    set_rd(4'd0);
    checks++; if (rd_data !== 8'h01) begin failures++; $display("FAIL ovf_rd0 got=%h exp=01", rd_data); end
    set_rd(4'd11);
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL ovf_rd11 got=%h exp=00", rd_data); end
    set_rd(4'd15);
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL ovf_rd15 got=%h exp=00", rd_data); end
  endtask

  task automatic test_second_batch();
    int ready_seen;
    ready_seen = 0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (in_ready !== 1'b0) ready_seen++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++; if (ready_seen !== 0) begin failures++; $display("FAIL wait_ready_cycles got=%0d exp=0", ready_seen); end
    set_rd(4'd0);
    checks++; if (rd_data !== 8'h01 || edge_count !== 4'd11) begin failures++; $display("FAIL wait_frozen got=%h/%0d exp=01/11", rd_data, edge_count); end
    pulse_done();
    tick();
    tick();
    checks++; if (edge_count !== 4'd11 || err_overflow !== 1'b1) begin failures++; $display("FAIL batch2_hold got=%0d/%0b exp=11/1", edge_count, err_overflow); end
    send_beat(8'h9A, 1'b1);
    checks++; if (edge_count !== 4'd1) begin failures++; $display("FAIL batch2_count got=%0d exp=1", edge_count); end
    checks++; if ({err_selfloop, err_overflow} !== 2'b00) begin failures++; $display("FAIL batch2_flags got=%b exp=00", {err_selfloop, err_overflow}); end
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL batch2_start got=%0b exp=1", start); end
    set_rd(4'd0);
    checks++; if (rd_data !== 8'h9A) begin failures++; $display("FAIL batch2_rd0 got=%h exp=9a", rd_data); end
    set_rd(4'd1);
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL batch2_rd1 got=%h exp=00", rd_data); end
    tick();
  endtask

  task automatic test_gaps();
    logic       vld [7];
    logic [7:0] dat [3];
    int         k;
    int         not_ready;
    int         extra_start;
    vld = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    dat = '{8'h45, 8'h67, 8'h89};
    k = 0;
    not_ready = 0;
    extra_start = 0;
    // router_done held for two edges: second one lands in S_LOAD and is ignored.
    router_done = 1'b1;
    tick();
    tick();
    router_done = 1'b0;
    checks++; if (in_ready !== 1'b1 || edge_count !== 4'd1) begin failures++; $display("FAIL gap_held_done got=%0b/%0d exp=1/1", in_ready, edge_count); end
    for (int c = 0; c < 7; c++) begin
      in_valid    = vld[c];
      in_data     = vld[c] ? dat[k] : 8'hFF;
      in_last     = vld[c] && (k == 2);
      router_done = (c == 2);
      if (in_ready !== 1'b1) not_ready++;
      tick();
      if (vld[c]) k++;
    end
    router_done = 1'b0;
    checks++; if (not_ready !== 0) begin failures++; $display("FAIL gap_ready_low got=%0d exp=0", not_ready); end
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL gap_start got=%0b exp=1", start); end
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (in_ready !== 1'b0) not_ready++;
      tick();
      if (start !== 1'b0) extra_start++;
    end
    in_valid = 1'b0;
    checks++; if (not_ready !== 0 || extra_start !== 0) begin failures++; $display("FAIL gap_busy_accept got=%0d/%0d exp=0/0", not_ready, extra_start); end
    checks++; if (edge_count !== 4'd3) begin failures++; $display("FAIL gap_count got=%0d exp=3", edge_count); end
    set_rd(4'd0);
    checks++; if (rd_data !== 8'h45) begin failures++; $display("FAIL gap_rd0 got=%h exp=45", rd_data); end
    set_rd(4'd1);
    checks++; if (rd_data !== 8'h67) begin failures++; $display("FAIL gap_rd1 got=%h exp=67", rd_data); end
    set_rd(4'd2);
    checks++; if (rd_data !== 8'h89) begin failures++; $display("FAIL gap_rd2 got=%h exp=89", rd_data); end
    set_rd(4'd3);
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL gap_rd3 got=%h exp=00", rd_data); end
  endtask

  task automatic test_reset_in_wait();
    pulse_done();
    send_beat(8'h10, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h20, 1'b0);
    send_beat(8'h30, 1'b0);
    send_beat(8'h40, 1'b0);
    send_beat(8'h50, 1'b1);
    tick();
    checks++; if (edge_count !== 4'd5 || err_selfloop !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL rstw_pre got=%0d/%0b/%0b exp=5/1/0", edge_count, err_selfloop, in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_rd(4'd0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstw_ready got=%0b exp=1", in_ready); end
    checks++; if (edge_count !== 4'd0 || err_selfloop !== 1'b0) begin failures++; $display("FAIL rstw_state got=%0d/%0b exp=0/0", edge_count, err_selfloop); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rstw_rd0 got=%h exp=00", rd_data); end
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL rstw_start got=%0b exp=0", start); end
    tick();
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL rstw_start_next got=%0b exp=0", start); end
    send_beat(8'h21, 1'b1);
    set_rd(4'd0);
    checks++; if (edge_count !== 4'd1 || rd_data !== 8'h21 || start !== 1'b1) begin failures++; $display("FAIL rstw_reload got=%0d/%h/%0b exp=1/21/1", edge_count, rd_data, start); end
    tick();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_last     = 1'b0;
    router_done = 1'b0;
    rd_addr     = 4'd0;
    test_reset();
    test_basic();
    test_selfloop();
    test_overflow();
    test_second_batch();
    test_gaps();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
